// File: rtl/urs_pio_pkg.sv
// Shared definitions for the URS input PIO: register addresses, edge-capture
// modes and the per-bit edge detector used by urs_0_pio_in.
package urs_pio_pkg;

  localparam int unsigned PIO_DATA_W = 32;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Vectors are zero-extended to the full bus width; the caller keeps its own slice.
  function automatic logic [PIO_DATA_W-1:0] pio_edge_flags(
    input edge_type_e             et,
    input logic [PIO_DATA_W-1:0]  val,
    input logic [PIO_DATA_W-1:0]  prev
  );
    logic [PIO_DATA_W-1:0] flags;
    case (et)
      EDGE_RISE: flags = val & ~prev;
      EDGE_FALL: flags = ~val & prev;
      default:   flags = val ^ prev;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/urs_0_pio_in_if.sv
// Avalon-MM slave bus of the input PIO; the CPU side is the master modport.
interface urs_0_pio_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/urs_0_pio_in_debounce.sv
// Single-bit debouncer: the stable output follows the input only after the
// input has disagreed with it for DEBOUNCE_CYCLES+1 consecutive cycles.
module urs_0_pio_in_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_stable
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_din == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_stable <= i_din;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/urs_0_pio_in.sv
// Avalon-MM input PIO: synchronises in_port, captures per-bit edges and raises a
// masked level irq. Define URS_PIO_IN_DEBOUNCE_EN to insert a per-bit debouncer.
module urs_0_pio_in
  import urs_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 14,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  urs_0_pio_in_if.slave      avs,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0]      r_sync1;
  logic [WIDTH-1:0]      r_sync2;
  logic [WIDTH-1:0]      r_prev;
  logic [WIDTH-1:0]      r_edge_capture;
  logic [WIDTH-1:0]      r_irq_mask;
  logic [PIO_DATA_W-1:0] r_readdata;

  logic [WIDTH-1:0]      w_val;
  logic [WIDTH-1:0]      w_edge;
  logic [WIDTH-1:0]      w_clear;
  logic [PIO_DATA_W-1:0] w_val_ext;
  logic [PIO_DATA_W-1:0] w_prev_ext;
  logic [PIO_DATA_W-1:0] w_edge_all;
  logic [PIO_DATA_W-1:0] w_rd_mux;
  logic                  w_wr;
  logic                  w_wr_mask;
  logic                  w_wr_edge;
  logic                  w_unused;

`ifdef URS_PIO_IN_DEBOUNCE_EN
  for (genvar b = 0; b < WIDTH; b++) begin : g_deb
    urs_0_pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .i_din    (r_sync2[b]),
      .o_stable (w_val[b])
    );
  end
`else
  assign w_val = r_sync2;
`endif

  assign w_wr      = avs.chipselect & ~avs.write_n;
  assign w_wr_mask = w_wr && (avs.address == PIO_ADDR_MASK);
  assign w_wr_edge = w_wr && (avs.address == PIO_ADDR_EDGE);
  assign w_clear   = w_wr_edge ? avs.writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_val_ext  = '0;
    w_prev_ext = '0;
    w_val_ext[WIDTH-1:0]  = w_val;
    w_prev_ext[WIDTH-1:0] = r_prev;
    w_edge_all = pio_edge_flags(EDGE_SEL, w_val_ext, w_prev_ext);
    w_edge     = w_edge_all[WIDTH-1:0];
  end

  always_comb begin
    w_rd_mux = '0;
    case (avs.address)
      PIO_ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_val;
      PIO_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      PIO_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_capture;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_prev         <= '0;
      r_edge_capture <= '0;
      r_irq_mask     <= '0;
      r_readdata     <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= w_val;
      // Set after clear, so a new edge survives a same-cycle clear of its bit.
      r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
      if (w_wr_mask) begin
        r_irq_mask <= avs.writedata[WIDTH-1:0];
      end
      r_readdata <= w_rd_mux;
    end
  end

  assign avs.readdata = r_readdata;
  assign irq          = |(r_edge_capture & r_irq_mask);

  // Bits above WIDTH and the debounce depth are unused in some configurations.
  assign w_unused = &{1'b0, avs.writedata, w_edge_all, DEBOUNCE_CYCLES[0]};

endmodule

// File: tb/tb_urs_0_pio_in.sv
// Bench for urs_0_pio_in: one DUT per edge mode shares stimulus; a history-based
// reference model feeds a readdata scoreboard and a per-cycle irq expectation.
module tb_urs_0_pio_in;
  import urs_pio_pkg::*;

  localparam int W   = 14;
  localparam int DEB = 16;

  logic          clk;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd [3];
  logic [2:0]    irq_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    urs_0_pio_in_if bus ();
    assign bus.address    = address;
    assign bus.chipselect = chipselect;
    assign bus.write_n    = write_n;
    assign bus.writedata  = writedata;
    assign rd[g]          = bus.readdata;
    urs_0_pio_in #(
      .WIDTH           (W),
      .EDGE_TYPE       (g),
      .DEBOUNCE_CYCLES (DEB)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .avs     (bus.slave),
      .in_port (in_port),
      .irq     (irq_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]      ph [2];   // ph[0]: in_port taken at last edge, ph[1]: one edge earlier
  logic [W-1:0]      vh [2];   // accepted value after last edge and one edge earlier
  logic [W-1:0]      ec [3];
  logic [W-1:0]      mask;
  logic [W-1:0]      stab;
  int                cnt [W];
  logic [2:0][31:0]  exp_q [$];
  logic              rd_req;
  logic              rvalid;
  logic [2:0]        irq_exp;
  bit                started;

  int checks;
  int errors;

  function automatic logic [W-1:0] ref_edges(input int t, input logic [W-1:0] v, input logic [W-1:0] p);
    if (t == 0) return v & ~p;
    if (t == 1) return ~v & p;
    return v ^ p;
  endfunction

  // Advances the model across the coming clock edge, using the inputs now driven.
  task automatic model_step();
    logic [W-1:0]     vpre, ppre, s2pre, clr, vnew;
    logic [2:0][31:0] e;
    vpre  = vh[0];
    ppre  = vh[1];
    s2pre = ph[1];
    e     = '0;
    if (reset) begin
      ph[0] = '0; ph[1] = '0; vh[0] = '0; vh[1] = '0;
      for (int g = 0; g < 3; g++) ec[g] = '0;
      mask = '0;
      stab = '0;
      for (int b = 0; b < W; b++) cnt[b] = 0;
      started = 1'b1;
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (address == PIO_ADDR_DATA)      e[g] = 32'(vpre);
        else if (address == PIO_ADDR_MASK) e[g] = 32'(mask);
        else if (address == PIO_ADDR_EDGE) e[g] = 32'(ec[g]);
      end
      clr = (chipselect && !write_n && address == PIO_ADDR_EDGE) ? writedata[W-1:0] : '0;
      for (int g = 0; g < 3; g++) ec[g] = (ec[g] & ~clr) | ref_edges(g, vpre, ppre);
      if (chipselect && !write_n && address == PIO_ADDR_MASK) mask = writedata[W-1:0];
      ph[1] = ph[0];
      ph[0] = in_port;
`ifdef URS_PIO_IN_DEBOUNCE_EN
      for (int b = 0; b < W; b++) begin
        if (s2pre[b] == stab[b]) cnt[b] = 0;
        else if (cnt[b] == DEB) begin stab[b] = s2pre[b]; cnt[b] = 0; end
        else cnt[b] = cnt[b] + 1;
      end
      vnew = stab;
`else
      vnew = ph[1];
`endif
      vh[1] = vh[0];
      vh[0] = vnew;
    end
    if (rd_req) exp_q.push_back(e);
    rvalid = rd_req;
    for (int g = 0; g < 3; g++) irq_exp[g] = |(ec[g] & mask);
  endtask

  task automatic cyc(input logic [1:0] a, input logic cs, input logic wr, input logic [31:0] wd, input logic r);
    address    = a;
    chipselect = cs;
    write_n    = ~wr;
    writedata  = wd;
    rd_req     = r;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(2'd1, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd_at(input logic [1:0] a);
    cyc(a, 1'b1, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic wr_at(input logic [1:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b1, d, 1'b0);
  endtask

  // Monitor: scoreboard pops on each presented read, irq checked every cycle.
  always @(posedge clk) begin
    #1;
    if (started) begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (irq_v[g] !== irq_exp[g]) begin
          errors++;
          $display("FAIL irq_et%0d t=%0t got %b exp %b", g, $time, irq_v[g], irq_exp[g]);
        end
      end
      if (rvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow t=%0t got empty exp entry", $time);
        end else begin
          logic [2:0][31:0] e;
          e = exp_q.pop_front();
          for (int g = 0; g < 3; g++) begin
            checks++;
            if (rd[g] !== e[g]) begin
              errors++;
              $display("FAIL readdata_et%0d t=%0t got %h exp %h", g, $time, rd[g], e[g]);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0; rd_req = 1'b0; rvalid = 1'b0;
    irq_exp = '0; started = 1'b0; checks = 0; errors = 0;
    repeat (3) idle();
    reset = 1'b0;

    // Reset values of every register
    for (int a = 0; a < 4; a++) rd_at(2'(a));
    idle();

    // Rising edge on bit 0 reaches irq, then write-1-to-clear drops it
    wr_at(PIO_ADDR_MASK, 32'h1);
    in_port = 14'h0001;
    repeat (5) rd_at(PIO_ADDR_EDGE);
    wr_at(PIO_ADDR_EDGE, 32'h1);
    repeat (2) rd_at(PIO_ADDR_EDGE);

    // Bit 3 edge lands on the same edge as its clear
    in_port = 14'h0009;
    idle();
    idle();
    wr_at(PIO_ADDR_EDGE, 32'h8);
    repeat (2) rd_at(PIO_ADDR_EDGE);

    // All bits captured with mask off, then one mask bit raises irq
    wr_at(PIO_ADDR_MASK, 32'h0);
    in_port = '0;
    repeat (4) idle();
    wr_at(PIO_ADDR_EDGE, 32'hFFFF_FFFF);
    in_port = 14'h3FFF;
    repeat (4) idle();
    rd_at(PIO_ADDR_EDGE);
    rd_at(PIO_ADDR_DATA);
    wr_at(PIO_ADDR_MASK, 32'h2000);
    rd_at(PIO_ADDR_MASK);
    rd_at(PIO_ADDR_EDGE);

    // Three-cycle pulse on bit 5
    in_port = '0;
    repeat (4) idle();
    wr_at(PIO_ADDR_EDGE, 32'hFFFF_FFFF);
    wr_at(PIO_ADDR_MASK, 32'h3FFF);
    in_port = 14'h0020;
    repeat (3) idle();
    in_port = '0;
    repeat (4) idle();
    rd_at(PIO_ADDR_DATA);
    rd_at(PIO_ADDR_EDGE);
    rd_at(2'd1);

    // Randomised traffic
    repeat (400) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ W'($urandom);
      case ($urandom_range(5))
        0, 1:    idle();
        2:       rd_at(2'($urandom_range(3)));
        3:       wr_at(PIO_ADDR_MASK, $urandom);
        4:       wr_at(PIO_ADDR_EDGE, $urandom);
        default: wr_at(2'($urandom_range(1)), $urandom);
      endcase
    end

    // Reset mid-traffic clears everything
    in_port = 14'h1555;
    reset = 1'b1;
    idle();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) rd_at(2'(a));

`ifdef URS_PIO_IN_DEBOUNCE_EN
    in_port = '0;
    wr_at(PIO_ADDR_MASK, 32'h3FFF);
    repeat (40) idle();
    wr_at(PIO_ADDR_EDGE, 32'hFFFF_FFFF);
    // Short glitch is rejected
    in_port = 14'h0080;
    repeat (10) rd_at(PIO_ADDR_DATA);
    in_port = '0;
    repeat (30) rd_at(PIO_ADDR_DATA);
    rd_at(PIO_ADDR_EDGE);
    // Long level is accepted
    in_port = 14'h0080;
    repeat (30) rd_at(PIO_ADDR_DATA);
    rd_at(PIO_ADDR_EDGE);
    in_port = '0;
    repeat (30) idle();
    // Reset during a count drops the pending change
    in_port = 14'h0100;
    repeat (10) idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    in_port = '0;
    repeat (30) rd_at(PIO_ADDR_DATA);
    rd_at(PIO_ADDR_EDGE);
`endif

    repeat (3) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
